hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_ctrl_sat_counter16.sv | 33 +++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared pipeline defines for the hazard controller: FSM state encodings,
// counter width/saturation constants and the load-use detection helper.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

   // FSM state encodings (2-bit)
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_LU_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH    = 2'd2;
   localparam logic [1:0] ST_HALT     = 2'd3;

   // Event counter width and its saturation value
   localparam int unsigned          CNT_W   = 16;
   localparam logic [CNT_W-1:0]     CNT_MAX = 16'hFFFF;

   // Load in EX writes a register that the instruction in ID reads.
   // x0 is never a real destination, so a load to x0 cannot create a hazard.
   function automatic logic is_load_use(input logic       mem_read,
                                        input logic [4:0] ex_rd,
                                        input logic [4:0] id_rs1,
                                        input logic [4:0] id_rs2);
      return mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the hazard controller's pipeline-facing signals.
//   Inputs to the controller : IF_ID_RegisterRs1/Rs2, ID_EX_RegisterRd,
//                              ID_EX_MemRead, branch_taken, halt_req, mem_busy
//   Outputs of the controller: pc_write, IF_ID_write, ID_EX_bubble, flush,
//                              pipe_hold, halted, stall_cnt, flush_cnt
// master = pipeline side (drives events), slave = hazard controller.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   logic [4:0]       IF_ID_RegisterRs1;
   logic [4:0]       IF_ID_RegisterRs2;
   logic [4:0]       ID_EX_RegisterRd;
   logic             ID_EX_MemRead;
   logic             branch_taken;
   logic             halt_req;
   logic             mem_busy;
   logic             pc_write;
   logic             IF_ID_write;
   logic             ID_EX_bubble;
   logic             flush;
   logic             pipe_hold;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output IF_ID_RegisterRs1, IF_ID_RegisterRs2, ID_EX_RegisterRd, ID_EX_MemRead,
             branch_taken, halt_req, mem_busy,
      input  pc_write, IF_ID_write, ID_EX_bubble, flush, pipe_hold, halted,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  IF_ID_RegisterRs1, IF_ID_RegisterRs2, ID_EX_RegisterRd, ID_EX_MemRead,
             branch_taken, halt_req, mem_busy,
      output pc_write, IF_ID_write, ID_EX_bubble, flush, pipe_hold, halted,
             stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter16.sv
// -----------------------------------------------------------------------------
// sat_counter16
// Event counter that saturates at its maximum value instead of wrapping.
//   clk     : rising-edge clock
//   rst     : synchronous active-high clear
//   i_inc   : count one event this cycle
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter16
   import hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Count register: clears on reset, sticks at CNT_MAX once reached
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= CNT_W'(0);
      end else if (i_inc && (r_count != CNT_MAX)) begin
         r_count <= r_count + CNT_W'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: load-use stall, branch flush, memory-busy hold
// and halt. Control outputs are combinational from state and current inputs;
// state and event counters update on the rising clock edge.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   hz  : hazard_ctrl_if.slave (pipeline events in, pipeline controls out)
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   hazard_ctrl_if.slave hz
);

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             w_lu;
   logic             w_pc_write;
   logic             w_if_id_write;
   logic             w_bubble;
   logic             w_flush;
   logic             w_hold;
   logic             w_halted;
   logic             w_stall_inc;
   logic             w_flush_inc;
   logic [CNT_W-1:0] w_stall_cnt;
   logic [CNT_W-1:0] w_flush_cnt;

   assign w_lu = is_load_use(hz.ID_EX_MemRead, hz.ID_EX_RegisterRd,
                             hz.IF_ID_RegisterRs1, hz.IF_ID_RegisterRs2);

   // Event priority resolution: halt > branch > mem_busy > load-use
   always_comb begin
      w_next        = r_state;
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_bubble      = 1'b0;
      w_flush       = 1'b0;
      w_hold        = 1'b0;
      w_halted      = 1'b0;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;
      case (r_state)
         ST_HALT: begin
            w_halted = 1'b1;
         end
         ST_RUN, ST_LU_STALL, ST_FLUSH: begin
            if (hz.halt_req) begin
               w_flush = 1'b1;
               w_next  = ST_HALT;
            end else if (hz.branch_taken) begin
               // redirect: PC takes the target, younger stages are squashed
               w_flush       = 1'b1;
               w_pc_write    = 1'b1;
               w_if_id_write = 1'b1;
               w_flush_inc   = 1'b1;
               w_next        = ST_FLUSH;
            end else if (hz.mem_busy) begin
               w_hold = 1'b1;
            end else if ((r_state == ST_RUN) && w_lu) begin
               // LU_STALL and FLUSH skip this so a hazard costs one bubble and
               // a squashed IF/ID cannot stall
               w_bubble    = 1'b1;
               w_stall_inc = 1'b1;
               w_next      = ST_LU_STALL;
            end else begin
               w_pc_write    = 1'b1;
               w_if_id_write = 1'b1;
               w_next        = ST_RUN;
            end
         end
         default: begin
            w_next = ST_RUN;
         end
      endcase
   end

   // State register with synchronous reset to RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next;
      end
   end

   sat_counter16 u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_stall_inc),
      .o_count (w_stall_cnt)
   );

   sat_counter16 u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_flush_inc),
      .o_count (w_flush_cnt)
   );

   assign hz.pc_write     = w_pc_write;
   assign hz.IF_ID_write  = w_if_id_write;
   assign hz.ID_EX_bubble = w_bubble;
   assign hz.flush        = w_flush;
   assign hz.pipe_hold    = w_hold;
   assign hz.halted       = w_halted;
   assign hz.stall_cnt    = w_stall_cnt;
   assign hz.flush_cnt    = w_flush_cnt;

endmodule
